instr_mem_loadable: RTL and testbench

- Parametrised, synchronous-read instruction memory for the MIPS pipeline fetch stage.
- Adds a byte-serial load port, driven by the debug/UART unit, so programs can be written at run time instead of only at elaboration.
- Load FSM assembles bytes into words, auto-increments the write pointer and stops on a HALT word or when memory is full.
- Fetch side: 1-cycle registered read with stall, alignment and range checking.

---
 rtl/instr_mem_loadable.sv | 122 ++++++++++++
 tb/tb_instr_mem_loadable.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Synchronous-read instruction memory with a byte-serial program load port.
// A load FSM assembles MSB-first bytes into words and stops on HALT_WORD or when memory is full.
module instr_mem_loadable #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DEPTH      = 512,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = DATA_WIDTH'(32'hFFFF_FFFF),
  localparam int unsigned         BYTES      = DATA_WIDTH / 8,
  localparam int unsigned         IDX_W      = $clog2(DEPTH),
  localparam int unsigned         CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load_start,
  input  logic                  i_load_byte_valid,
  input  logic [7:0]            i_load_byte,
  output logic                  o_load_ready,
  output logic                  o_load_done,
  output logic                  o_load_overflow,
  output logic [CNT_W-1:0]      o_load_count,
  input  logic                  i_fetch_en,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic                  o_instr_valid,
  output logic                  o_addr_fault
);

  localparam int unsigned BCW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state_q, state_d;
  logic [BCW-1:0]        byte_cnt_q;
  logic [CNT_W-1:0]      ptr_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic                  ovf_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  accept, last_byte, word_wr, full, is_halt;
  logic [DATA_WIDTH-1:0] asm_next;
  logic [IDX_W-1:0]      rd_idx;
  logic                  fault;

  always_comb begin
    accept    = (state_q == LOAD) && !i_load_start && i_load_byte_valid;
    last_byte = byte_cnt_q == BCW'(BYTES - 1);
    word_wr   = accept && last_byte;
    asm_next  = (asm_q << 8) | DATA_WIDTH'(i_load_byte);
    full      = ptr_q == CNT_W'(DEPTH - 1);
    is_halt   = asm_next == HALT_WORD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_load_start) state_d = LOAD;
      LOAD: if (word_wr && (is_halt || full)) state_d = DONE;
      DONE: if (i_load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Start restarts from word 0 in any state and always beats a same-cycle byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      ptr_q      <= '0;
      asm_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (i_load_start) begin
      byte_cnt_q <= '0;
      ptr_q      <= '0;
      asm_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (accept) begin
      asm_q <= asm_next;
      if (last_byte) begin
        byte_cnt_q <= '0;
        ptr_q      <= ptr_q + CNT_W'(1);
        ovf_q      <= full && !is_halt;
      end else begin
        byte_cnt_q <= byte_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_wr) mem[ptr_q[IDX_W-1:0]] <= asm_next;
  end

  always_comb begin
    rd_idx = i_fetch_addr[IDX_W+1:2];
    fault  = (i_fetch_addr[1:0] != 2'b00) || ((i_fetch_addr >> (IDX_W + 2)) != '0);
  end

  // Non-blocking read of mem gives read-before-write on a same-word collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_instruction <= '0;
      o_instr_valid <= 1'b0;
      o_addr_fault  <= 1'b0;
    end else if (i_fetch_en) begin
      o_instruction <= fault ? '0 : ((state_q == DONE) ? mem[rd_idx] : '0);
      o_addr_fault  <= fault;
      o_instr_valid <= (state_q == DONE) && !fault;
    end
  end

  always_comb begin
    o_load_ready    = state_q == LOAD;
    o_load_done     = state_q == DONE;
    o_load_overflow = ovf_q;
    o_load_count    = ptr_q;
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed self-checking bench: instance a uses default DEPTH=512, instance b uses DEPTH=4.
module tb_instr_mem_loadable;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 0, a_valid = 0, a_fen = 0;
  logic [7:0]  a_byte = 0;
  logic [31:0] a_faddr = 0;
  logic        a_ready, a_done, a_ovf, a_ivalid, a_fault;
  logic [9:0]  a_count;
  logic [31:0] a_instr;

  logic        b_start = 0, b_valid = 0, b_fen = 0;
  logic [7:0]  b_byte = 0;
  logic [31:0] b_faddr = 0;
  logic        b_ready, b_done, b_ovf, b_ivalid, b_fault;
  logic [2:0]  b_count;
  logic [31:0] b_instr;

  int checks = 0;
  int errors = 0;

  instr_mem_loadable u_a (
    .clk(clk), .rst_n(rst_n),
    .i_load_start(a_start), .i_load_byte_valid(a_valid), .i_load_byte(a_byte),
    .o_load_ready(a_ready), .o_load_done(a_done), .o_load_overflow(a_ovf),
    .o_load_count(a_count),
    .i_fetch_en(a_fen), .i_fetch_addr(a_faddr),
    .o_instruction(a_instr), .o_instr_valid(a_ivalid), .o_addr_fault(a_fault)
  );

  instr_mem_loadable #(.DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .i_load_start(b_start), .i_load_byte_valid(b_valid), .i_load_byte(b_byte),
    .o_load_ready(b_ready), .o_load_done(b_done), .o_load_overflow(b_ovf),
    .o_load_count(b_count),
    .i_fetch_en(b_fen), .i_fetch_addr(b_faddr),
    .o_instruction(b_instr), .o_instr_valid(b_ivalid), .o_addr_fault(b_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    a_start = 1; step(); a_start = 0;
  endtask

  task automatic send_a(input logic [7:0] b);
    a_valid = 1; a_byte = b; step(); a_valid = 0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_valid = 1; b_byte = b; step(); b_valid = 0;
  endtask

  task automatic fetch_a(input logic [31:0] addr);
    a_fen = 1; a_faddr = addr; step(); a_fen = 0;
  endtask

  task automatic fetch_b(input logic [31:0] addr);
    b_fen = 1; b_faddr = addr; step(); b_fen = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    step(); step();
    checks++;
    if ({a_ready, a_done, a_ovf, a_ivalid, a_fault} !== 5'b0 || a_count !== 10'd0 || a_instr !== 32'd0) begin
      errors++;
      $display("FAIL reset_a: flags=%b count=%0d instr=%h, expected all zero",
               {a_ready, a_done, a_ovf, a_ivalid, a_fault}, a_count, a_instr);
    end
    checks++;
    if ({b_ready, b_done, b_ovf, b_ivalid, b_fault} !== 5'b0 || b_count !== 3'd0 || b_instr !== 32'd0) begin
      errors++;
      $display("FAIL reset_b: flags=%b count=%0d instr=%h, expected all zero",
               {b_ready, b_done, b_ovf, b_ivalid, b_fault}, b_count, b_instr);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_load();
    logic [7:0] prog [12] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07,
                              8'hFF, 8'hFF, 8'hFF, 8'hFF};
    start_a();
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready: got %b expected 1", a_ready);
    end
    for (int i = 0; i < 12; i++) send_a(prog[i]);
    checks++;
    if (a_done !== 1'b1 || a_count !== 10'd3 || a_ovf !== 1'b0 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_done: done=%b count=%0d ovf=%b ready=%b expected 1/3/0/0",
               a_done, a_count, a_ovf, a_ready);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] exp [3] = '{32'h2008_0005, 32'h2009_0007, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      fetch_a(32'(i * 4));
      checks++;
      if (a_instr !== exp[i] || a_ivalid !== 1'b1 || a_fault !== 1'b0) begin
        errors++;
        $display("FAIL fetch_%0d: instr=%h valid=%b fault=%b expected %h/1/0",
                 i, a_instr, a_ivalid, a_fault, exp[i]);
      end
    end
  endtask

  task automatic test_fault();
    fetch_a(32'h2);
    checks++;
    if (a_fault !== 1'b1 || a_instr !== 32'd0 || a_ivalid !== 1'b0) begin
      errors++;
      $display("FAIL fault_misalign: fault=%b instr=%h valid=%b expected 1/0/0", a_fault, a_instr, a_ivalid);
    end
    fetch_a(32'h800);
    checks++;
    if (a_fault !== 1'b1 || a_instr !== 32'd0 || a_ivalid !== 1'b0) begin
      errors++;
      $display("FAIL fault_range: fault=%b instr=%h valid=%b expected 1/0/0", a_fault, a_instr, a_ivalid);
    end
    fetch_a(32'h7FC);
    checks++;
    if (a_fault !== 1'b0 || a_instr !== 32'd0 || a_ivalid !== 1'b1) begin
      errors++;
      $display("FAIL fault_lastword: fault=%b instr=%h valid=%b expected 0/0/1", a_fault, a_instr, a_ivalid);
    end
  endtask

  task automatic test_stall();
    fetch_a(32'h4);
    a_faddr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_instr !== 32'h2009_0007 || a_ivalid !== 1'b1) begin
        errors++;
        $display("FAIL stall_%0d: instr=%h valid=%b expected 20090007/1", i, a_instr, a_ivalid);
      end
    end
  endtask

  task automatic test_restart();
    start_a();
    send_a(8'hAA);
    send_a(8'hBB);
    a_start = 1; a_valid = 1; a_byte = 8'hCC; step(); a_start = 0; a_valid = 0;
    send_a(8'h11); send_a(8'h22); send_a(8'h33); send_a(8'h44);
    checks++;
    if (a_count !== 10'd1 || a_ready !== 1'b1 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_count: count=%0d ready=%b done=%b expected 1/1/0", a_count, a_ready, a_done);
    end
    fetch_a(32'h0);
    checks++;
    if (a_ivalid !== 1'b0 || a_instr !== 32'd0 || a_fault !== 1'b0) begin
      errors++;
      $display("FAIL fetch_in_load: valid=%b instr=%h fault=%b expected 0/0/0", a_ivalid, a_instr, a_fault);
    end
    for (int i = 0; i < 4; i++) send_a(8'hFF);
    checks++;
    if (a_done !== 1'b1 || a_count !== 10'd2) begin
      errors++;
      $display("FAIL restart_done: done=%b count=%0d expected 1/2", a_done, a_count);
    end
    fetch_a(32'h0);
    checks++;
    if (a_instr !== 32'h1122_3344 || a_ivalid !== 1'b1) begin
      errors++;
      $display("FAIL restart_word0: instr=%h valid=%b expected 11223344/1", a_instr, a_ivalid);
    end
  endtask

  task automatic test_overflow();
    b_start = 1; step(); b_start = 0;
    for (int i = 1; i <= 16; i++) send_b(8'(i));
    checks++;
    if (b_done !== 1'b1 || b_ovf !== 1'b1 || b_count !== 3'd4 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow: done=%b ovf=%b count=%0d ready=%b expected 1/1/4/0",
               b_done, b_ovf, b_count, b_ready);
    end
    for (int i = 0; i < 4; i++) send_b(8'h99);
    checks++;
    if (b_count !== 3'd4 || b_done !== 1'b1) begin
      errors++;
      $display("FAIL overflow_extra: count=%0d done=%b expected 4/1", b_count, b_done);
    end
    fetch_b(32'h0);
    checks++;
    if (b_instr !== 32'h0102_0304 || b_ivalid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_word0: instr=%h valid=%b expected 01020304/1", b_instr, b_ivalid);
    end
    fetch_b(32'hC);
    checks++;
    if (b_instr !== 32'h0D0E_0F10 || b_ivalid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_word3: instr=%h valid=%b expected 0d0e0f10/1", b_instr, b_ivalid);
    end
    fetch_b(32'h10);
    checks++;
    if (b_fault !== 1'b1 || b_instr !== 32'd0 || b_ivalid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_range: fault=%b instr=%h valid=%b expected 1/0/0", b_fault, b_instr, b_ivalid);
    end
  endtask

  task automatic test_reset_mid_load();
    start_a();
    send_a(8'h12); send_a(8'h34); send_a(8'h56); send_a(8'h78);
    send_a(8'hAA); send_a(8'hBB); send_a(8'hCC); send_a(8'hDD);
    send_a(8'h01); send_a(8'h02);
    fetch_a(32'h2);
    checks++;
    if (a_fault !== 1'b1 || a_count !== 10'd2) begin
      errors++;
      $display("FAIL pre_reset: fault=%b count=%0d expected 1/2", a_fault, a_count);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({a_ready, a_done, a_ovf, a_ivalid, a_fault} !== 5'b0 || a_count !== 10'd0 || a_instr !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: flags=%b count=%0d instr=%h expected all zero",
               {a_ready, a_done, a_ovf, a_ivalid, a_fault}, a_count, a_instr);
    end
    step();
    rst_n = 1;
    step();
    checks++;
    if (a_ready !== 1'b0 || a_done !== 1'b0 || a_count !== 10'd0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b done=%b count=%0d expected 0/0/0", a_ready, a_done, a_count);
    end
    send_a(8'h55);
    checks++;
    if (a_ready !== 1'b0 || a_count !== 10'd0) begin
      errors++;
      $display("FAIL idle_byte: ready=%b count=%0d expected 0/0", a_ready, a_count);
    end
    start_a();
    for (int i = 0; i < 4; i++) send_a(8'hFF);
    checks++;
    if (a_done !== 1'b1 || a_count !== 10'd1 || a_ovf !== 1'b0) begin
      errors++;
      $display("FAIL halt_only: done=%b count=%0d ovf=%b expected 1/1/0", a_done, a_count, a_ovf);
    end
    fetch_a(32'h0);
    checks++;
    if (a_instr !== 32'hFFFF_FFFF || a_ivalid !== 1'b1) begin
      errors++;
      $display("FAIL halt_word0: instr=%h valid=%b expected ffffffff/1", a_instr, a_ivalid);
    end
    fetch_a(32'h4);
    checks++;
    if (a_instr !== 32'hAABB_CCDD || a_ivalid !== 1'b1) begin
      errors++;
      $display("FAIL survive_word1: instr=%h valid=%b expected aabbccdd/1", a_instr, a_ivalid);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_fault();
    test_stall();
    test_restart();
    test_overflow();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
